logic_gate_tester: RTL

LOGIC_GATE_TESTER -- requirements
Module: logic_gate_tester

---
 rtl/logic_gate_tester_if.sv | 24 ++
 rtl/logic_gate_tester.sv | 131 +++++++++++++
 2 files changed

// File: rtl/logic_gate_tester_if.sv
// Signal bundle between the gate-bank tester and its environment.
// The tester takes the slave side; whoever drives start/abort and the gate bank takes the master side.
interface logic_gate_tester_if;
    logic        start;
    logic        abort;
    logic        a_o;
    logic        b_o;
    logic [6:0]  y_i;
    logic        busy;
    logic        done;
    logic        pass;
    logic [6:0]  fail_mask;
    logic [27:0] capture;

    modport master (
        output start, abort, y_i,
        input  a_o, b_o, busy, done, pass, fail_mask, capture
    );

    modport slave (
        input  start, abort, y_i,
        output a_o, b_o, busy, done, pass, fail_mask, capture
    );
endinterface

// File: rtl/logic_gate_tester.sv
// Sweeps {a,b} through 00..11 into an external 2-input gate bank and compares
// each sampled 7-gate result against the known truth table.
module logic_gate_tester #(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_gate_tester_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [1:0]  v_q, v_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        a_q, a_d;
    logic        b_q, b_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [6:0]  fail_mask_q, fail_mask_d;
    logic [27:0] capture_q, capture_d;

    logic [6:0]  golden;
    logic [4:0]  slot;
    logic        sample_edge;

    // Expected {XNOR,XOR,NOR,NAND,NOTa,OR,AND} for each operand pair.
    always_comb begin
        golden = 7'h00;
        case (v_q)
            2'd0: golden = 7'h5C;
            2'd1: golden = 7'h2E;
            2'd2: golden = 7'h2A;
            2'd3: golden = 7'h43;
            default: golden = 7'h00;
        endcase
    end

    assign slot        = {3'd0, v_q} * 5'd7;
    assign sample_edge = (cnt_q == 4'd1);

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        capture_d   = capture_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d     = RUN;
                    v_d         = 2'd0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    cnt_d       = SETTLE_CNT;
                    fail_mask_d = 7'h00;
                    pass_d      = 1'b0;
                    capture_d   = 28'h0;
                end
            end
            RUN: begin
                // Abort wins over a coincident sample so partial results stay as they were.
                if (bus.abort) begin
                    state_d = IDLE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = 4'd0;
                end else if (sample_edge) begin
                    capture_d   = (capture_q & ~(28'h7F << slot)) | ({21'd0, bus.y_i} << slot);
                    fail_mask_d = fail_mask_q | (bus.y_i ^ golden);
                    if (v_q == 2'd3) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        pass_d  = (fail_mask_d == 7'h00);
                        cnt_d   = 4'd0;
                    end else begin
                        v_d        = v_q + 2'd1;
                        {a_d, b_d} = v_q + 2'd1;
                        cnt_d      = SETTLE_CNT;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            v_q         <= 2'd0;
            cnt_q       <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 7'h00;
            capture_q   <= 28'h0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            capture_q   <= capture_d;
        end
    end

    assign bus.a_o       = a_q;
    assign bus.b_o       = b_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.capture   = capture_q;

endmodule
